// File: rtl/exu_disp_oitf_pkg.sv
// Shared widths, the OITF entry layout and the per-entry hazard match helper
// for the dispatch/OITF block.
package exu_disp_oitf_pkg;

  localparam int DEF_XLEN          = 32;
  localparam int DEF_PC_SIZE       = 32;
  localparam int DEF_RFIDX_WIDTH   = 5;
  localparam int DEF_DECINFO_WIDTH = 32;
  localparam int DEF_OITF_DEPTH    = 4;

  typedef struct packed {
    logic                       vld;
    logic                       rdwen;
    logic [DEF_RFIDX_WIDTH-1:0] rdidx;
  } oitf_entry_t;

  // x0 is never a real destination, so an entry writing x0 cannot cause a hazard.
  function automatic logic entry_hit(input oitf_entry_t e,
                                     input logic [DEF_RFIDX_WIDTH-1:0] idx);
    return e.vld & e.rdwen & (e.rdidx != '0) & (e.rdidx == idx);
  endfunction

endpackage

// File: rtl/exu_disp_oitf_tbl.sv
// Outstanding-instruction track FIFO: circular entry table with wrap-bit pointers,
// empty/full status, head contents and per-source hazard match vectors.
module exu_oitf_tbl
  import exu_disp_oitf_pkg::*;
#(
  parameter int OITF_DEPTH  = DEF_OITF_DEPTH,
  parameter int ITAG_WIDTH  = $clog2(OITF_DEPTH),
  parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_alc_ena,
  input  logic                   i_alc_rdwen,
  input  logic [RFIDX_WIDTH-1:0] i_alc_rdidx,
  input  logic                   i_ret_ena,
  input  logic [RFIDX_WIDTH-1:0] i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] i_rdidx,
  output logic [ITAG_WIDTH-1:0]  o_alc_ptr,
  output logic [ITAG_WIDTH-1:0]  o_ret_ptr,
  output logic [RFIDX_WIDTH-1:0] o_ret_rdidx,
  output logic                   o_ret_rdwen,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [OITF_DEPTH-1:0]  o_rs1_match,
  output logic [OITF_DEPTH-1:0]  o_rs2_match,
  output logic [OITF_DEPTH-1:0]  o_rd_match
);

  if (RFIDX_WIDTH != DEF_RFIDX_WIDTH) begin : g_bad_rfidx
    $error("exu_oitf_tbl: RFIDX_WIDTH must match the package entry layout");
  end
  if ((OITF_DEPTH < 2) || ((OITF_DEPTH & (OITF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("exu_oitf_tbl: OITF_DEPTH must be a power of two and at least 2");
  end

  // The extra MSB is the wrap bit; with a power-of-two depth a plain increment
  // returns the index to 0 and toggles the wrap bit together.
  logic [ITAG_WIDTH:0]   r_alc_ptr;
  logic [ITAG_WIDTH:0]   r_ret_ptr;
  oitf_entry_t           r_entry [OITF_DEPTH];

  logic [ITAG_WIDTH-1:0] w_alc_idx;
  logic [ITAG_WIDTH-1:0] w_ret_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_ret_fire;

  assign w_alc_idx  = r_alc_ptr[ITAG_WIDTH-1:0];
  assign w_ret_idx  = r_ret_ptr[ITAG_WIDTH-1:0];
  assign w_empty    = (r_alc_ptr == r_ret_ptr);
  assign w_full     = (w_alc_idx == w_ret_idx) & (r_alc_ptr[ITAG_WIDTH] != r_ret_ptr[ITAG_WIDTH]);
  assign w_ret_fire = i_ret_ena & ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alc_ptr <= '0;
      r_ret_ptr <= '0;
    end else begin
      if (i_alc_ena) begin
        r_alc_ptr <= r_alc_ptr + 1'b1;
      end
      if (w_ret_fire) begin
        r_ret_ptr <= r_ret_ptr + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < OITF_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_entry[gi] <= '0;
      end else if (i_alc_ena && (w_alc_idx == ITAG_WIDTH'(gi))) begin
        r_entry[gi] <= '{vld: 1'b1, rdwen: i_alc_rdwen, rdidx: i_alc_rdidx};
      end else if (w_ret_fire && (w_ret_idx == ITAG_WIDTH'(gi))) begin
        r_entry[gi].vld <= 1'b0;
      end
    end

    assign o_rs1_match[gi] = entry_hit(r_entry[gi], i_rs1idx);
    assign o_rs2_match[gi] = entry_hit(r_entry[gi], i_rs2idx);
    assign o_rd_match[gi]  = entry_hit(r_entry[gi], i_rdidx);
  end

  assign o_alc_ptr   = w_alc_idx;
  assign o_ret_ptr   = w_ret_idx;
  assign o_ret_rdidx = r_entry[w_ret_idx].rdidx;
  assign o_ret_rdwen = r_entry[w_ret_idx].rdwen;
  assign o_empty     = w_empty;
  assign o_full      = w_full;

endmodule

// File: rtl/exu_disp_oitf.sv
// Dispatch stage: hazard/fence/full gating in front of the ALU plus allocation
// of OITF entries for decode-predicted long-pipe instructions.
module exu_disp_oitf
  import exu_disp_oitf_pkg::*;
#(
  parameter int XLEN          = DEF_XLEN,
  parameter int PC_SIZE       = DEF_PC_SIZE,
  parameter int RFIDX_WIDTH   = DEF_RFIDX_WIDTH,
  parameter int DECINFO_WIDTH = DEF_DECINFO_WIDTH,
  parameter int OITF_DEPTH    = DEF_OITF_DEPTH,
  parameter int ITAG_WIDTH    = $clog2(OITF_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_i_valid,
  output logic                     disp_i_ready,
  input  logic                     disp_i_rs1en,
  input  logic                     disp_i_rs2en,
  input  logic                     disp_i_rdwen,
  input  logic [RFIDX_WIDTH-1:0]   disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0]   disp_i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0]   disp_i_rdidx,
  input  logic [XLEN-1:0]          disp_i_rs1,
  input  logic [XLEN-1:0]          disp_i_rs2,
  input  logic [XLEN-1:0]          disp_i_imm,
  input  logic [DECINFO_WIDTH-1:0] disp_i_info,
  input  logic [PC_SIZE-1:0]       disp_i_pc,
  input  logic                     disp_i_ilegl,
  input  logic                     disp_i_longp,
  input  logic                     disp_i_fence,
  output logic                     disp_o_alu_valid,
  input  logic                     disp_o_alu_ready,
  output logic [XLEN-1:0]          disp_o_alu_rs1,
  output logic [XLEN-1:0]          disp_o_alu_rs2,
  output logic [XLEN-1:0]          disp_o_alu_imm,
  output logic                     disp_o_alu_rdwen,
  output logic [RFIDX_WIDTH-1:0]   disp_o_alu_rdidx,
  output logic [DECINFO_WIDTH-1:0] disp_o_alu_info,
  output logic [PC_SIZE-1:0]       disp_o_alu_pc,
  output logic                     disp_o_alu_ilegl,
  output logic                     disp_o_alu_longp,
  output logic [ITAG_WIDTH-1:0]    disp_o_alu_itag,
  input  logic                     oitf_ret_ena,
  output logic [ITAG_WIDTH-1:0]    oitf_ret_ptr,
  output logic [RFIDX_WIDTH-1:0]   oitf_ret_rdidx,
  output logic                     oitf_ret_rdwen,
  output logic                     oitf_empty,
  output logic                     oitf_full
);

  logic [OITF_DEPTH-1:0] w_rs1_match;
  logic [OITF_DEPTH-1:0] w_rs2_match;
  logic [OITF_DEPTH-1:0] w_rd_match;
  logic                  w_raw;
  logic                  w_waw;
  logic                  w_cond;
  logic                  w_alc_ena;

  // The ALU never feeds back into this decision; long-pipe comes from decode.
  assign w_raw  = (disp_i_rs1en & (|w_rs1_match)) | (disp_i_rs2en & (|w_rs2_match));
  assign w_waw  = disp_i_rdwen & (|w_rd_match);
  assign w_cond = ~w_raw & ~w_waw
                & (~disp_i_longp | ~oitf_full)
                & (~disp_i_fence | oitf_empty);

  assign disp_o_alu_valid = disp_i_valid & w_cond;
  assign disp_i_ready     = w_cond & disp_o_alu_ready;
  assign w_alc_ena        = disp_o_alu_valid & disp_o_alu_ready & disp_i_longp;

  exu_oitf_tbl #(
    .OITF_DEPTH  (OITF_DEPTH),
    .ITAG_WIDTH  (ITAG_WIDTH),
    .RFIDX_WIDTH (RFIDX_WIDTH)
  ) u_oitf_tbl (
    .clk         (clk),
    .rst         (rst),
    .i_alc_ena   (w_alc_ena),
    .i_alc_rdwen (disp_i_rdwen),
    .i_alc_rdidx (disp_i_rdidx),
    .i_ret_ena   (oitf_ret_ena),
    .i_rs1idx    (disp_i_rs1idx),
    .i_rs2idx    (disp_i_rs2idx),
    .i_rdidx     (disp_i_rdidx),
    .o_alc_ptr   (disp_o_alu_itag),
    .o_ret_ptr   (oitf_ret_ptr),
    .o_ret_rdidx (oitf_ret_rdidx),
    .o_ret_rdwen (oitf_ret_rdwen),
    .o_empty     (oitf_empty),
    .o_full      (oitf_full),
    .o_rs1_match (w_rs1_match),
    .o_rs2_match (w_rs2_match),
    .o_rd_match  (w_rd_match)
  );

  assign disp_o_alu_rs1   = disp_i_rs1;
  assign disp_o_alu_rs2   = disp_i_rs2;
  assign disp_o_alu_imm   = disp_i_imm;
  assign disp_o_alu_rdwen = disp_i_rdwen;
  assign disp_o_alu_rdidx = disp_i_rdidx;
  assign disp_o_alu_info  = disp_i_info;
  assign disp_o_alu_pc    = disp_i_pc;
  assign disp_o_alu_ilegl = disp_i_ilegl;
  assign disp_o_alu_longp = disp_i_longp;

endmodule
